iob_uart2iob_master: RTL and testbench
======================================

Name: iob_uart2iob_master

Overview:
Serial-to-bus bridge: a UART host (debugger or PC script) drives IOb native-bus transactions into the SoC. Contains a UART 8N1 receiver and transmitter, a command-frame parser and an IOb initiator. It is the initiating counterpart of the IOb-responder UART peripheral: it sits on the bus as a manager and reaches any IOb peripheral, including iob_uart registers.

Parameters:
ADDR_W, 32, IOb address width (1..32); frame address bits above ADDR_W-1 are discarded
DATA_W, 32, IOb data width; fixed at 32
DIV_W, 16, width of the bit-duration divisor input
TIMEOUT_CYC, 100000, inter-byte timeout in clk cycles (used only with the optional feature)

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
div_i  in  DIV_W  clk cycles per UART bit; must be >= 4 and held stable while busy
rxd_i  in  1  serial in, idle high
txd_o  out  1  serial out, idle high
iob_valid_o  out  1  request valid
iob_addr_o  out  ADDR_W  request address
iob_wdata_o  out  32  write data
iob_wstrb_o  out  4  byte strobes: 4'hF = write, 4'h0 = read
iob_ready_i  in  1  responder accepts request
iob_rvalid_i  in  1  read data valid
iob_rdata_i  in  32  read data
busy_o  out  1  frame in progress (parser not in IDLE)
frame_err_o  out  1  one-cycle pulse on UART stop-bit error or bad command

Behaviour:
- Reset: clock and reset are as stated under Ports (single clock clk_i; arst_n_i asynchronous, active-low). Reset values: txd_o=1, iob_valid_o=0, iob_addr_o=0, iob_wdata_o=0, iob_wstrb_o=0, busy_o=0, frame_err_o=0. All FSMs go to IDLE.
- RX: rxd_i passes through a 2-FF synchroniser. In RX idle, a falling edge starts a counter. Sample at div_i/2: if high, it is a false start; return to idle. Otherwise sample 8 data bits LSB-first, each div_i cycles later, then the stop bit. Stop=1: one-cycle rx_byte strobe. Stop=0: drop the byte, pulse frame_err_o, force the parser to IDLE.
- TX: 8N1 LSB-first. Start bit, 8 data bits and stop bit each last exactly div_i cycles. Next byte starts no earlier than the cycle after its stop bit ends.
- Frame format (multi-byte fields little-endian):
  - write = 0x57, A0..A3, D0..D3
  - read = 0x52, A0..A3
- Parser FSM:
  - IDLE: byte 0x57/0x52 -> ADDR, count=0. Any other byte -> queue reply 0xEE, pulse frame_err_o, stay IDLE.
  - ADDR: 4 bytes -> DATA (write) or REQ (read).
  - DATA: 4 bytes -> REQ.
  - REQ: iob_valid_o=1 with stable addr/wdata/wstrb, held until the cycle iob_ready_i=1. That cycle is the handshake; iob_valid_o=0 next cycle. Write -> RESP with reply 0x06. Read -> RWAIT.
  - RWAIT: capture iob_rdata_i on iob_rvalid_i (same cycle as ready allowed) -> RESP, reply R0..R3.
  - RESP: transmit reply bytes back-to-back -> IDLE.
- Bytes received while in REQ, RWAIT or RESP are discarded; no buffering.
- Latency: iob_valid_o rises the cycle after the last frame byte's rx strobe. The first reply start bit begins no later than 2 cycles after the handshake (write) or the rvalid cycle (read).
- Reset mid-frame or mid-transfer: everything aborts immediately; txd_o=1 on the next edge.

Optional Feature:
UART2IOB_TIMEOUT_EN
- Defined: a counter clears on every rx byte and runs while the parser is in ADDR or DATA. Reaching TIMEOUT_CYC forces IDLE, pulses frame_err_o and sends no reply.
- Undefined: no counter; a partial frame waits indefinitely.

Test Plan:
- div_i=8; send 57 10 00 00 00 EF BE AD DE; responder ready after 3 cycles -> one handshake with addr=0x10, wdata=0xDEADBEEF, wstrb=F; txd carries 0x06.
- div_i=8; send 52 04 00 00 00; rvalid 5 cycles after ready with rdata=0x12345678 -> wstrb=0, addr=0x04; txd carries 78 56 34 12.
- Send 0x41 -> txd carries 0xEE, frame_err_o pulses once, busy_o stays 0; a following valid write frame completes normally.
- Send 52 with stop bit driven low -> frame_err_o pulse, no bus request; the next valid read frame succeeds.
- Assert arst_n_i during RWAIT -> iob_valid_o=0, txd_o=1, busy_o=0; a fresh read frame then completes correctly.
- With UART2IOB_TIMEOUT_EN, TIMEOUT_CYC=200: send 57 10, then idle for 250 cycles -> frame_err_o pulse, busy_o=0, no request, no reply. Without the macro: busy_o stays 1.

Source files
------------

// File: rtl/iob_uart2iob_master.sv
// -----------------------------------------------------------------------------
// iob_uart2iob_master
// UART (8N1) to IOb-native bus bridge. A host on the serial line sends command
// frames; the bridge issues one IOb request per frame and answers on txd_o.
//   write frame : 0x57 A0 A1 A2 A3 D0 D1 D2 D3   -> reply 0x06
//   read  frame : 0x52 A0 A1 A2 A3               -> reply R0 R1 R2 R3
//   unknown command byte                          -> reply 0xEE
// Multi-byte fields are little-endian.
//
// Ports:
//   clk_i, arst_n_i      clock, asynchronous active-low reset
//   div_i                clk cycles per UART bit (>= 4, stable while busy)
//   rxd_i / txd_o        serial in / out, idle high
//   iob_valid_o ...      IOb request (addr, wdata, wstrb F=write 0=read)
//   iob_ready_i          responder accepts the request
//   iob_rvalid_i/rdata_i read response
//   busy_o               a frame is in progress (parser not idle)
//   frame_err_o          one-cycle pulse: bad stop bit, bad command, timeout
//
// Optional build macro UART2IOB_TIMEOUT_EN: abandons a partial frame (no
// reply) after TIMEOUT_CYC cycles without a received byte.
// -----------------------------------------------------------------------------
module iob_uart2iob_master #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DIV_W       = 16,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DIV_W-1:0]  div_i,
    input  logic              rxd_i,
    output logic              txd_o,
    output logic              iob_valid_o,
    output logic [ADDR_W-1:0] iob_addr_o,
    output logic [DATA_W-1:0] iob_wdata_o,
    output logic [3:0]        iob_wstrb_o,
    input  logic              iob_ready_i,
    input  logic              iob_rvalid_i,
    input  logic [DATA_W-1:0] iob_rdata_i,
    output logic              busy_o,
    output logic              frame_err_o
);

    localparam logic [7:0] CMD_WR = 8'h57;
    localparam logic [7:0] CMD_RD = 8'h52;
    localparam logic [7:0] ACK    = 8'h06;
    localparam logic [7:0] NAK    = 8'hEE;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [3:0]        wstrb;
    } req_t;

    logic [DIV_W-1:0] bit_last, half_last;
    assign bit_last  = div_i - DIV_W'(1);
    assign half_last = (div_i >> 1) - DIV_W'(1);

    // ------------------------------------------------------------------ RX
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;

    rx_st_t           rx_st;
    logic             rx_s1, rx_s2, rx_d;
    logic [DIV_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_sh;   // holds the received byte while rx_stb is high
    logic             rx_stb, rx_err;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rx_s1  <= 1'b1;
            rx_s2  <= 1'b1;
            rx_d   <= 1'b1;
            rx_st  <= RX_IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh  <= '0;
            rx_stb <= 1'b0;
            rx_err <= 1'b0;
        end else begin
            rx_s1  <= rxd_i;
            rx_s2  <= rx_s1;
            rx_d   <= rx_s2;
            rx_stb <= 1'b0;
            rx_err <= 1'b0;
            case (rx_st)
                // Edge detect, not level: after a bad stop bit the line may
                // still be low and must not be taken as a new start bit.
                RX_IDLE: if (rx_d && !rx_s2) begin
                    rx_st  <= RX_START;
                    rx_cnt <= '0;
                end
                RX_START: if (rx_cnt == half_last) begin
                    rx_cnt <= '0;
                    rx_bit <= '0;
                    rx_st  <= rx_s2 ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt <= rx_cnt + DIV_W'(1);
                end
                RX_DATA: if (rx_cnt == bit_last) begin
                    rx_cnt <= '0;
                    rx_sh  <= {rx_s2, rx_sh[7:1]};
                    rx_bit <= rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_st <= RX_STOP;
                end else begin
                    rx_cnt <= rx_cnt + DIV_W'(1);
                end
                RX_STOP: if (rx_cnt == bit_last) begin
                    rx_st <= RX_IDLE;
                    if (rx_s2) rx_stb <= 1'b1;
                    else       rx_err <= 1'b1;
                end else begin
                    rx_cnt <= rx_cnt + DIV_W'(1);
                end
                default: rx_st <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------ TX
    logic             tx_busy, tx_go;
    logic [7:0]       tx_byte;
    logic [8:0]       tx_sh;   // data bits then stop bit, LSB out first
    logic [3:0]       tx_bit;
    logic [DIV_W-1:0] tx_cnt;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            txd_o   <= 1'b1;
            tx_busy <= 1'b0;
            tx_sh   <= '1;
            tx_bit  <= '0;
            tx_cnt  <= '0;
        end else if (!tx_busy) begin
            if (tx_go) begin
                txd_o   <= 1'b0;
                tx_sh   <= {1'b1, tx_byte};
                tx_bit  <= '0;
                tx_cnt  <= '0;
                tx_busy <= 1'b1;
            end
        end else if (tx_cnt == bit_last) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
                tx_busy <= 1'b0;
            end else begin
                txd_o  <= tx_sh[0];
                tx_sh  <= {1'b1, tx_sh[8:1]};
                tx_bit <= tx_bit + 4'd1;
            end
        end else begin
            tx_cnt <= tx_cnt + DIV_W'(1);
        end
    end

    // -------------------------------------------------------------- parser
    typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_REQ, P_RWAIT, P_RESP} p_st_t;

    p_st_t       p_st;
    logic        is_wr;
    logic [1:0]  byte_cnt;
    logic [31:0] addr_sh, data_sh, addr_nxt, data_nxt;
    logic [31:0] rep;        // reply bytes, shifted out LSB first
    logic [1:0]  rep_left;   // reply bytes remaining after the current one
    logic        nak_pend;   // 0xEE waiting for the transmitter
    logic        timeout;
    req_t        req;

    assign addr_nxt    = {rx_sh, addr_sh[31:8]};
    assign data_nxt    = {rx_sh, data_sh[31:8]};
    assign iob_valid_o = req.valid;
    assign iob_addr_o  = req.addr;
    assign iob_wdata_o = req.wdata;
    assign iob_wstrb_o = req.wstrb;
    assign busy_o      = (p_st != P_IDLE);

    // A frame reply owns the transmitter; a pending NAK goes out when it is free.
    always_comb begin
        tx_go   = 1'b0;
        tx_byte = NAK;
        if (!tx_busy) begin
            if (p_st == P_RESP) begin
                tx_go   = 1'b1;
                tx_byte = rep[7:0];
            end else if (nak_pend) begin
                tx_go   = 1'b1;
            end
        end
    end

`ifdef UART2IOB_TIMEOUT_EN
    logic [31:0] to_cnt;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)                                        to_cnt <= '0;
        else if (rx_stb || !(p_st inside {P_ADDR, P_DATA}))   to_cnt <= '0;
        else                                                  to_cnt <= to_cnt + 32'd1;
    end

    assign timeout = (p_st inside {P_ADDR, P_DATA}) && !rx_stb &&
                     (to_cnt == 32'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            p_st        <= P_IDLE;
            is_wr       <= 1'b0;
            byte_cnt    <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            rep         <= '0;
            rep_left    <= '0;
            nak_pend    <= 1'b0;
            req         <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            if (tx_go && p_st != P_RESP) nak_pend <= 1'b0;

            if (rx_err) begin
                // Once the bus transaction has started the byte would be
                // discarded anyway, so only the error pulse remains there.
                frame_err_o <= 1'b1;
                if (p_st inside {P_IDLE, P_ADDR, P_DATA}) p_st <= P_IDLE;
            end else if (timeout) begin
                frame_err_o <= 1'b1;
                p_st        <= P_IDLE;
            end else begin
                case (p_st)
                    P_IDLE: if (rx_stb) begin
                        if (rx_sh == CMD_WR || rx_sh == CMD_RD) begin
                            is_wr    <= (rx_sh == CMD_WR);
                            byte_cnt <= '0;
                            p_st     <= P_ADDR;
                        end else begin
                            nak_pend    <= 1'b1;
                            frame_err_o <= 1'b1;
                        end
                    end
                    P_ADDR: if (rx_stb) begin
                        addr_sh  <= addr_nxt;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (is_wr) begin
                                p_st <= P_DATA;
                            end else begin
                                p_st      <= P_REQ;
                                req.valid <= 1'b1;
                                req.addr  <= addr_nxt[ADDR_W-1:0];
                                req.wstrb <= 4'h0;
                            end
                        end
                    end
                    P_DATA: if (rx_stb) begin
                        data_sh  <= data_nxt;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            p_st      <= P_REQ;
                            req.valid <= 1'b1;
                            req.addr  <= addr_sh[ADDR_W-1:0];
                            req.wdata <= data_nxt;
                            req.wstrb <= 4'hF;
                        end
                    end
                    P_REQ: if (iob_ready_i) begin
                        req.valid <= 1'b0;
                        if (is_wr) begin
                            rep      <= {24'd0, ACK};
                            rep_left <= 2'd0;
                            p_st     <= P_RESP;
                        end else if (iob_rvalid_i) begin
                            rep      <= iob_rdata_i;
                            rep_left <= 2'd3;
                            p_st     <= P_RESP;
                        end else begin
                            p_st <= P_RWAIT;
                        end
                    end
                    P_RWAIT: if (iob_rvalid_i) begin
                        rep      <= iob_rdata_i;
                        rep_left <= 2'd3;
                        p_st     <= P_RESP;
                    end
                    P_RESP: if (tx_go) begin
                        rep <= {8'h00, rep[31:8]};
                        if (rep_left == 2'd0) p_st <= P_IDLE;
                        else                  rep_left <= rep_left - 2'd1;
                    end
                    default: p_st <= P_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_iob_uart2iob_master.sv
`timescale 1ns/1ps
module tb_iob_uart2iob_master;

    localparam int CLK_P = 10;
    localparam int DIV   = 8;

    logic        clk = 1'b0, arst_n = 1'b0, rxd = 1'b1;
    logic [15:0] div = 16'(DIV);
    logic        txd, iob_valid, iob_ready, iob_rvalid, busy, frame_err;
    logic [31:0] iob_addr, iob_wdata, iob_rdata;
    logic [3:0]  iob_wstrb;

    always #(CLK_P/2) clk = ~clk;

    iob_uart2iob_master #(.ADDR_W(32), .DATA_W(32), .DIV_W(16), .TIMEOUT_CYC(200)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .div_i(div), .rxd_i(rxd), .txd_o(txd),
        .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
        .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid),
        .iob_rdata_i(iob_rdata), .busy_o(busy), .frame_err_o(frame_err)
    );

    int n_vec = 0, n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------------------------------------------- serial decoder
    logic [7:0] tx_q[$];
    time        tx_t[$];
    int         tx_stop_bad = 0;

    initial begin : tx_mon
        logic [7:0] b;
        time        t;
        forever begin
            @(negedge txd);
            t = $time;
            repeat (DIV/2) @(posedge clk);
            #1;
            if (txd == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(posedge clk);
                    #1;
                    b[i] = txd;
                end
                repeat (DIV) @(posedge clk);
                #1;
                if (txd !== 1'b1) tx_stop_bad++;
                tx_q.push_back(b);
                tx_t.push_back(t);
            end
        end
    end

    int err_cnt = 0;
    bit busy_seen = 0;
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_cnt++;
        if (busy === 1'b1) busy_seen = 1;
    end

    // ---------------------------------------------------- IOb responder
    int          rdy_dly = 0, rv_dly = 0, hs_cnt = 0;
    logic [31:0] rsp_rdata = 0, hs_addr = 0, hs_wdata = 0;
    logic [3:0]  hs_wstrb = 0;
    time         done_t = 0;
    bit          rsp_busy = 0;

    initial begin : responder
        bit rd;
        iob_ready = 0; iob_rvalid = 0; iob_rdata = 0;
        forever begin
            @(posedge clk);
            #1;
            if (iob_valid === 1'b1 && arst_n) begin
                rsp_busy = 1;
                repeat (rdy_dly) begin @(posedge clk); #1; end
                check("valid_held", iob_valid, 1);
                rd       = (iob_wstrb == 4'h0);
                hs_addr  = iob_addr;
                hs_wdata = iob_wdata;
                hs_wstrb = iob_wstrb;
                iob_ready = 1;
                if (rd && rv_dly == 0) begin iob_rvalid = 1; iob_rdata = rsp_rdata; end
                @(posedge clk);
                done_t = $time;
                hs_cnt++;
                #1;
                iob_ready = 0; iob_rvalid = 0;
                check("valid_drop", iob_valid, 0);
                if (rd && rv_dly > 0) begin
                    repeat (rv_dly - 1) begin @(posedge clk); #1; end
                    iob_rvalid = 1; iob_rdata = rsp_rdata;
                    @(posedge clk);
                    done_t = $time;
                    #1;
                    iob_rvalid = 0;
                end
                rsp_busy = 0;
            end
        end
    end

    // ---------------------------------------------------- stimulus helpers
    task automatic send_byte(input logic [7:0] b, input bit stop);
        rxd = 1'b0;
        wait_cyc(DIV);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            wait_cyc(DIV);
        end
        rxd = stop;
        wait_cyc(DIV);
        rxd = 1'b1;
    endtask

    task automatic clear_obs();
        tx_q.delete(); tx_t.delete();
        hs_cnt = 0; err_cnt = 0; busy_seen = 0; tx_stop_bad = 0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] wdata);
        send_byte(cmd, 1'b1);
        if (cmd == 8'h57 || cmd == 8'h52)
            for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8], 1'b1);
        if (cmd == 8'h57)
            for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8], 1'b1);
    endtask

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] addr, wdata, rdata;
        int          rdy, rv;
        bit          e_hs;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
        int          e_n;
        logic [31:0] e_rep;
        int          e_err;
        bit          e_busy;
    } vec_t;

    task automatic run_frame(input string tag, input vec_t v);
        int budget;
        rdy_dly = v.rdy; rv_dly = v.rv; rsp_rdata = v.rdata;
        clear_obs();
        send_frame(v.cmd, v.addr, v.wdata);
        budget = 0;
        while (tx_q.size() < v.e_n && budget < 3000) begin wait_cyc(1); budget++; end
        wait_cyc(12*DIV);
        check({tag, " hs_cnt"}, hs_cnt, 32'(v.e_hs));
        if (v.e_hs && hs_cnt > 0) begin
            check({tag, " addr"}, hs_addr, v.e_addr);
            check({tag, " wstrb"}, hs_wstrb, v.e_wstrb);
            if (v.e_wstrb == 4'hF) check({tag, " wdata"}, hs_wdata, v.e_wdata);
        end
        check({tag, " reply_cnt"}, tx_q.size(), v.e_n);
        for (int i = 0; i < v.e_n && i < tx_q.size(); i++)
            check($sformatf("%s reply[%0d]", tag, i), tx_q[i], v.e_rep[8*i +: 8]);
        if (v.e_hs && tx_t.size() > 0)
            check({tag, " reply_latency_ok"}, 32'((tx_t[0] - done_t) <= 2*CLK_P), 1);
        check({tag, " err_pulses"}, err_cnt, v.e_err);
        check({tag, " busy_seen"}, 32'(busy_seen), 32'(v.e_busy));
        check({tag, " tx_stop"}, tx_stop_bad, 0);
        check({tag, " busy_end"}, busy, 0);
    endtask

    // Reference: what a frame must produce, straight from the frame rules.
    function automatic vec_t model(input logic [7:0] cmd, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [31:0] rdata,
                                   input int rdy, input int rv);
        vec_t r;
        r = '{cmd, addr, wdata, rdata, rdy, rv, 0, 0, 0, 4'h0, 1, 32'hEE, 1, 0};
        if (cmd == 8'h57) begin
            r.e_hs = 1; r.e_addr = addr; r.e_wdata = wdata; r.e_wstrb = 4'hF;
            r.e_n = 1; r.e_rep = 32'h06; r.e_err = 0; r.e_busy = 1;
        end else if (cmd == 8'h52) begin
            r.e_hs = 1; r.e_addr = addr; r.e_wstrb = 4'h0;
            r.e_n = 4; r.e_rep = rdata; r.e_err = 0; r.e_busy = 1;
        end
        return r;
    endfunction

    initial begin : watchdog
        #(CLK_P * 95000);
        $display("FAIL watchdog: simulation did not finish (%0d vectors, %0d miscompares)", n_vec, n_err);
        $fatal(1);
    end

    // ---------------------------------------------------- main test
    vec_t vt[5];

    initial begin : main
        int b;
        vt[0] = '{8'h57, 32'h10, 32'hDEADBEEF, 32'h0, 3, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 32'h06, 0, 1};
        vt[1] = '{8'h52, 32'h04, 32'h0, 32'h12345678, 0, 5, 1, 32'h04, 32'h0, 4'h0, 4, 32'h12345678, 0, 1};
        vt[2] = '{8'h41, 32'h0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hEE, 1, 0};
        vt[3] = '{8'h57, 32'hA5A50004, 32'h0BADF00D, 32'h0, 0, 0, 1, 32'hA5A50004, 32'h0BADF00D, 4'hF, 1, 32'h06, 0, 1};
        vt[4] = '{8'h52, 32'h100, 32'h0, 32'hCAFE0001, 2, 0, 1, 32'h100, 32'h0, 4'h0, 4, 32'hCAFE0001, 0, 1};

        // reset state
        wait_cyc(3);
        check("rst txd", txd, 1);
        check("rst valid", iob_valid, 0);
        check("rst addr", iob_addr, 0);
        check("rst wdata", iob_wdata, 0);
        check("rst wstrb", iob_wstrb, 0);
        check("rst busy", busy, 0);
        check("rst frame_err", frame_err, 0);
        arst_n = 1'b1;
        wait_cyc(4);
        check("post-rst txd", txd, 1);

        for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vt[i]);

        // bad stop bit on a command byte, then a good read
        clear_obs();
        send_byte(8'h52, 1'b0);
        wait_cyc(4*DIV);
        check("stoperr err_pulses", err_cnt, 1);
        check("stoperr hs_cnt", hs_cnt, 0);
        check("stoperr busy", busy, 0);
        check("stoperr reply_cnt", tx_q.size(), 0);
        run_frame("after_stoperr", model(8'h52, 32'h20, 32'h0, 32'h55AA33CC, 1, 2));

        // reset while waiting for read data
        clear_obs();
        rdy_dly = 0; rv_dly = 60; rsp_rdata = 32'hFFFF0000;
        send_frame(8'h52, 32'h08, 32'h0);
        b = 0;
        while (hs_cnt == 0 && b < 1000) begin wait_cyc(1); b++; end
        check("rwait hs_cnt", hs_cnt, 1);
        wait_cyc(5);
        check("rwait busy", busy, 1);
        arst_n = 1'b0;
        #1;
        check("rwait rst valid", iob_valid, 0);
        check("rwait rst busy", busy, 0);
        wait_cyc(1);
        check("rwait rst txd", txd, 1);
        wait_cyc(3);
        arst_n = 1'b1;
        b = 0;
        while (rsp_busy && b < 200) begin wait_cyc(1); b++; end
        check("rwait responder_idle", 32'(rsp_busy), 0);
        wait_cyc(12*DIV);
        check("rwait no_reply", tx_q.size(), 0);
        run_frame("after_rst", model(8'h52, 32'h08, 32'h0, 32'h0F1E2D3C, 0, 3));

        // partial frame then silence
        clear_obs();
        send_byte(8'h57, 1'b1);
        send_byte(8'h10, 1'b1);
        wait_cyc(250);
`ifdef UART2IOB_TIMEOUT_EN
        check("timeout busy", busy, 0);
        check("timeout err_pulses", err_cnt, 1);
`else
        check("no_timeout busy", busy, 1);
        check("no_timeout err_pulses", err_cnt, 0);
`endif
        check("partial hs_cnt", hs_cnt, 0);
        check("partial reply_cnt", tx_q.size(), 0);
        arst_n = 1'b0;
        wait_cyc(2);
        arst_n = 1'b1;
        wait_cyc(4);

        // randomized frames against the reference model
        for (int i = 0; i < 8; i++) begin
            logic [7:0] c;
            int k;
            k = $urandom_range(0, 2);
            if (k == 0)      c = 8'h57;
            else if (k == 1) c = 8'h52;
            else begin
                c = 8'($urandom_range(0, 255));
                if (c == 8'h57 || c == 8'h52) c = 8'h00;
            end
            run_frame($sformatf("rnd%0d", i),
                      model(c, $urandom, $urandom, $urandom,
                            $urandom_range(0, 4), $urandom_range(0, 6)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
